// File: rtl/countdown_timer.sv
// Prescaled down-counter with one-shot/periodic reload, pause/resume and a one-cycle
// terminal-count pulse.
module countdown_timer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Load,
    input  logic [WIDTH-1:0]      Data_In,
    input  logic [PRESCALE_W-1:0] Prescale_In,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic                  Periodic,
    output logic [WIDTH-1:0]      Out,
    output logic                  Tc,
    output logic                  Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [WIDTH-1:0]      reload;
    logic [WIDTH-1:0]      reload_n;
    logic [WIDTH-1:0]      out_n;
    logic [PRESCALE_W-1:0] pre;
    logic [PRESCALE_W-1:0] pre_n;
    logic [PRESCALE_W-1:0] pc;
    logic [PRESCALE_W-1:0] pc_n;
    logic                  tc_n;
    logic                  busy_n;
    logic                  tick;
    logic                  resume;

    // State and datapath registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            reload <= '0;
            pre    <= '0;
            pc     <= '0;
            Out    <= '0;
            Tc     <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            state  <= state_n;
            reload <= reload_n;
            pre    <= pre_n;
            pc     <= pc_n;
            Out    <= out_n;
            Tc     <= tc_n;
            Busy   <= busy_n;
        end
    end

    // Next-state and datapath decode; Load overrides everything, Stop beats Start
    always_comb begin
        state_n  = state;
        reload_n = reload;
        pre_n    = pre;
        pc_n     = pc;
        out_n    = Out;
        tc_n     = 1'b0;
        tick     = (pc == pre);
        resume   = Start && !Stop;

        if (Load) begin
            reload_n = Data_In;
            out_n    = Data_In;
            pre_n    = Prescale_In;
            pc_n     = '0;
            state_n  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (resume && (reload != '0)) begin
                        out_n   = reload;
                        pc_n    = '0;
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (Stop) begin
                        state_n = PAUSED;
                    end else if (tick) begin
                        pc_n = '0;
                        if (Out > WIDTH'(1)) begin
                            out_n = Out - WIDTH'(1);
                        end else if (Out == WIDTH'(1)) begin
                            tc_n = 1'b1;
                            if (Periodic) begin
                                out_n = reload;
                            end else begin
                                out_n   = '0;
                                state_n = IDLE;
                            end
                        end else begin
                            // Out == 0 cannot be reached in RUN; never wrap, just stop
                            state_n = IDLE;
                        end
                    end else begin
                        pc_n = pc + PRESCALE_W'(1);
                    end
                end
                PAUSED: begin
                    if (resume) begin
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios with literal expectations plus random
// stimulus checked every cycle against an elapsed-time model of the timer.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Load = 1'b0;
    logic [7:0] Data_In = '0;
    logic [3:0] Prescale_In = '0;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic       Periodic = 1'b0;
    logic [7:0] Out;
    logic       Tc;
    logic       Busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    countdown_timer #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Load       (Load),
        .Data_In    (Data_In),
        .Prescale_In(Prescale_In),
        .Start      (Start),
        .Stop       (Stop),
        .Periodic   (Periodic),
        .Out        (Out),
        .Tc         (Tc),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: time is counted as RUN cycles elapsed since the count (re)started;
    // a tick lands on every multiple of P+1, and Out = Reload - ticks.
    int m_mode;       // 0 idle, 1 counting, 2 paused
    int m_out, m_reload, m_pre, m_elapsed, m_tc, m_ticks;

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            m_mode = 0; m_out = 0; m_reload = 0; m_pre = 0; m_elapsed = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            if (Load) begin
                m_reload = Data_In; m_out = Data_In; m_pre = Prescale_In;
                m_elapsed = 0; m_mode = 0;
            end else if (m_mode == 1) begin
                if (Stop) m_mode = 2;
                else begin
                    m_elapsed++;
                    if (m_elapsed % (m_pre + 1) == 0) begin
                        m_ticks = m_elapsed / (m_pre + 1);
                        if (m_ticks >= m_reload) begin
                            m_tc = 1;
                            m_elapsed = 0;
                            if (Periodic) m_out = m_reload;
                            else begin m_out = 0; m_mode = 0; end
                        end else m_out = m_reload - m_ticks;
                    end
                end
            end else if (m_mode == 0) begin
                if (Start && !Stop && m_reload != 0) begin
                    m_mode = 1; m_out = m_reload; m_elapsed = 0;
                end
            end else if (Start && !Stop) begin
                m_mode = 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started && !Reset) begin
            chk("model_out", int'(Out), m_out);
            chk("model_tc", int'(Tc), m_tc);
            chk("model_busy", int'(Busy), (m_mode != 0) ? 1 : 0);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_load(input int d, input int p);
        Load = 1'b1; Data_In = 8'(d); Prescale_In = 4'(p);
        cyc();
        Load = 1'b0;
    endtask

    int tc_hits[$];
    bit found;

    initial begin
        #1;
        chk("reset_out", int'(Out), 0);
        chk("reset_tc", int'(Tc), 0);
        chk("reset_busy", int'(Busy), 0);
        cyc();
        Reset = 1'b0;
        started = 1'b1;

        // One-shot 3, P=0: 3,2,1,0 with Tc on the 0
        cyc();
        do_load(3, 0);
        chk("os_loaded", int'(Out), 3);
        Periodic = 1'b0; Start = 1'b1;
        cyc();
        Start = 1'b0;
        chk("os_out3", int'(Out), 3);
        chk("os_busy", int'(Busy), 1);
        cyc(); chk("os_out2", int'(Out), 2);
        cyc(); chk("os_out1", int'(Out), 1); chk("os_tc_early", int'(Tc), 0);
        cyc(); chk("os_out0", int'(Out), 0); chk("os_tc", int'(Tc), 1); chk("os_busy_fall", int'(Busy), 0);
        cyc(); chk("os_tc_once", int'(Tc), 0);

        // Periodic 2, P=2: Tc every 6 cycles with Out reloaded
        do_load(2, 2);
        Periodic = 1'b1; Start = 1'b1;
        tc_hits.delete();
        for (int k = 1; k <= 14; k++) begin
            cyc();
            Start = 1'b0;
            if (k == 4) chk("per_out1", int'(Out), 1);
            if (Tc) begin
                tc_hits.push_back(k);
                chk("per_reload", int'(Out), 2);
            end
        end
        chk("per_tc_count", tc_hits.size(), 2);
        if (tc_hits.size() == 2) begin
            chk("per_first_tc", tc_hits[0], 7);
            chk("per_spacing", tc_hits[1] - tc_hits[0], 6);
        end

        // Pause at Out=5 for 4 cycles, then resume with no lost or extra tick
        Periodic = 1'b0;
        do_load(8, 1);
        Start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc();
            Start = 1'b0;
            if (Out == 8'd5) found = 1'b1;
        end
        chk("pause_reach5", int'(found), 1);
        Stop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("pause_hold", int'(Out), 5);
            chk("pause_busy", int'(Busy), 1);
        end
        Stop = 1'b0; Start = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= 30 && !found; k++) begin
            cyc();
            Start = 1'b0;
            if (Tc) begin
                found = 1'b1;
                chk("resume_tc_at", k, 11);
            end
        end
        chk("resume_tc_seen", int'(found), 1);

        // Reload of zero never starts; Load beats Start
        do_load(0, 0);
        Start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("zero_busy", int'(Busy), 0);
            chk("zero_tc", int'(Tc), 0);
        end
        Load = 1'b1; Data_In = 8'd9;
        cyc();
        Load = 1'b0; Start = 1'b0;
        chk("loadstart_out", int'(Out), 9);
        chk("loadstart_busy", int'(Busy), 0);

        // Start+Stop in RUN pauses; async reset mid-cycle clears outputs at once
        do_load(6, 3);
        Start = 1'b1;
        cyc(); Start = 1'b0;
        cyc();
        cyc();
        Start = 1'b1; Stop = 1'b1;
        cyc();
        Start = 1'b0; Stop = 1'b0;
        cyc();
        chk("both_paused_out", int'(Out), 6);
        chk("both_paused_busy", int'(Busy), 1);
        #2 Reset = 1'b1;
        #1;
        chk("areset_out", int'(Out), 0);
        chk("areset_busy", int'(Busy), 0);
        chk("areset_tc", int'(Tc), 0);
        Reset = 1'b0;

        // Random stimulus, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            cyc();
            Load        = ($urandom_range(0, 39) == 0);
            Data_In     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
            Prescale_In = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            Start       = ($urandom_range(0, 5) == 0);
            Stop        = ($urandom_range(0, 11) == 0);
            Periodic    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) begin
                #2 Reset = 1'b1;
                #1;
                chk("rand_areset_out", int'(Out), 0);
                chk("rand_areset_busy", int'(Busy), 0);
                #1 Reset = 1'b0;
            end
        end

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the width of the count and reload value.
REQ-002 SHALL have parameter PRESCALE_W, default 4, the width of the prescale value.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Load  input  1  capture Data_In and Prescale_In.
REQ-006 SHALL have port Data_In  input  WIDTH  reload value.
REQ-007 SHALL have port Prescale_In  input  PRESCALE_W  prescale value P; a tick occurs every P+1 cycles.
REQ-008 SHALL have port Start  input  1  start a count from IDLE, or resume from PAUSED.
REQ-009 SHALL have port Stop  input  1  pause a running count.
REQ-010 SHALL have port Periodic  input  1  1 = auto-reload at terminal count, 0 = one-shot; sampled on every tick.
REQ-011 SHALL have port Out  output  WIDTH  current count, registered.
REQ-012 SHALL have port Tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-013 SHALL have port Busy  output  1  high when the state is not IDLE.

Function
REQ-014 SHALL have three states: IDLE, RUN, PAUSED.
REQ-015 SHALL hold internal registers Reload (WIDTH bits), Pre (PRESCALE_W bits) and prescale counter Pc (PRESCALE_W bits).
REQ-016 Load, in any state: Reload and Out <= Data_In, Pre <= Prescale_In, Pc <= 0, state -> IDLE, Tc <= 0.
REQ-017 Load SHALL have priority over Start and Stop in the same cycle.
REQ-018 Start in IDLE with Reload != 0: Out <= Reload, Pc <= 0, state -> RUN.
REQ-019 Start in IDLE with Reload == 0 SHALL be ignored: state stays IDLE, no Tc.
REQ-020 In RUN, each cycle: if Pc == Pre then tick and Pc <= 0, else Pc <= Pc + 1.
REQ-021 On a tick with Out > 1: Out <= Out - 1.
REQ-022 On a tick with Out == 1 and Periodic = 1: Out <= Reload, Tc <= 1, stay in RUN.
REQ-023 On a tick with Out == 1 and Periodic = 0: Out <= 0, Tc <= 1, state -> IDLE.
REQ-024 Tc SHALL be 0 in every cycle that does not follow a terminal tick.
REQ-025 From Start to the first Tc: exactly Reload*(Pre+1) cycles; periodic Tc spacing SHALL be Reload*(Pre+1) cycles.
REQ-026 Stop in RUN: state -> PAUSED; Out and Pc held. Start in PAUSED: state -> RUN, resuming from the held Out and Pc.
REQ-027 Stop and Start asserted in the same cycle: Stop SHALL win.
REQ-028 Stop in IDLE or PAUSED, and Start in RUN, SHALL have no effect.
REQ-029 Out SHALL never wrap below 0; all arithmetic is modulo-free within WIDTH bits.
REQ-030 Pre == 0 SHALL produce a tick every RUN cycle.

Reset
REQ-031 Reset high SHALL immediately, regardless of clk, set state IDLE, Out = 0, Reload = 0, Pre = 0, Pc = 0, Tc = 0, Busy = 0.
REQ-032 Reset mid-count SHALL abort the count with no Tc; the first edge after deassertion obeys REQ-016..030.

Verification
REQ-033 Load Data_In=3, Prescale_In=0, Periodic=0, then Start -> Out goes 3,2,1,0 on successive cycles; Tc high once, with Out=0; Busy falls with Tc.
REQ-034 Load 2, Prescale_In=2, Periodic=1, then Start -> Tc every 6 cycles; Out reloads to 2 at each Tc.
REQ-035 Running with Out=5 -> Stop 4 cycles: Out stays 5, Busy=1. Then Start: counting resumes with no lost or extra tick.
REQ-036 Load 0, then Start -> Busy stays 0 and Tc never asserts; Load+Start in the same cycle -> IDLE with Out=Data_In.
REQ-037 Start and Stop together while in RUN -> PAUSED. Async Reset pulse between clk edges while in RUN -> outputs zero before the next edge.
